bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_pkg.sv | 33 +++
 rtl/arb_tenure_counter.sv | 42 ++++
 rtl/bus_arbiter.sv | 177 +++++++++++++++++
 tb/tb_bus_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the two-master bus arbiter: FSM state encoding,
// grant_id codes and the default maximum grant tenure.
package bus_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT1 = 2'd1,
        GRANT2 = 2'd2
    } arb_state_e;

    // Codes presented on grant_id
    typedef enum logic [1:0] {
        NONE = 2'd0,
        M1   = 2'd1,
        M2   = 2'd2
    } grant_id_e;

    // Default maximum tenure (cycles) while the other master is waiting
    localparam int unsigned MAX_HOLD_DEFAULT = 64;

    // Map an FSM state onto its grant_id code
    function automatic grant_id_e grant_code(input arb_state_e st);
        grant_id_e gid;
        case (st)
            GRANT1:  gid = M1;
            GRANT2:  gid = M2;
            default: gid = NONE;
        endcase
        return gid;
    endfunction

endpackage

// File: rtl/arb_tenure_counter.sv
// Grant tenure counter: cleared while no master owns the bus, counts every
// cycle of a grant and saturates at MAX_HOLD-1, which it flags on at_max_o.
module arb_tenure_counter #(
    parameter  int unsigned MAX_HOLD = 64,
    localparam int unsigned CNT_W    = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic at_max_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear wins, then saturating increment while enabled
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = {CNT_W{1'b0}};
        end else if (enable_i && (count_q != CNT_MAX)) begin
            count_d = count_q + CNT_W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= {CNT_W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign at_max_o = (count_q == CNT_MAX);

endmodule

// File: rtl/bus_arbiter.sv
// Two-master serial bus arbiter. Round-robin on contention, bounded tenure
// with preemption that never cuts a frame in flight (valid_x high), one dead
// IDLE cycle between owners, and strict isolation of the return path.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int unsigned MAX_HOLD = MAX_HOLD_DEFAULT
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       bus_req1,
    input  logic       bus_req2,
    input  logic       addr_tx1,
    input  logic       addr_tx2,
    input  logic       data_tx1,
    input  logic       data_tx2,
    input  logic       valid1,
    input  logic       valid2,
    input  logic       burst_mode1,
    input  logic       burst_mode2,
    input  logic       slave_data_rx,
    input  logic       slave_valid_in,
    input  logic       slave_ready_in,
    output logic       bus_ready1,
    output logic       bus_ready2,
    output logic       bus_addr,
    output logic       bus_data,
    output logic       bus_valid,
    output logic       bus_burst,
    output logic       data_rx1,
    output logic       data_rx2,
    output logic       slave_valid1,
    output logic       slave_valid2,
    output logic       slave_ready1,
    output logic       slave_ready2,
    output logic [1:0] grant_id
);

    arb_state_e state_q;
    arb_state_e state_d;
    logic       last_m2_q;   // 1: master 2 was served last
    logic       last_m2_d;
    logic       armed_q;     // blocks grants on the first edge after reset
    logic       ready1_q;
    logic       ready1_d;
    logic       ready2_q;
    logic       ready2_d;
    logic [1:0] gid_q;
    logic [1:0] gid_d;
    logic       at_max_s;

    arb_tenure_counter #(
        .MAX_HOLD (MAX_HOLD)
    ) u_tenure (
        .clock    (clock),
        .reset_n  (reset_n),
        .clear_i  (state_q == IDLE),
        .enable_i (state_q != IDLE),
        .at_max_o (at_max_s)
    );

    // Next-state, round-robin flag and registered-output next values
    always_comb begin
        state_d   = state_q;
        last_m2_d = last_m2_q;
        case (state_q)
            IDLE: begin
                if (!armed_q) begin
                    state_d = IDLE;
                end else if (bus_req1 && bus_req2) begin
                    state_d = last_m2_q ? GRANT1 : GRANT2;
                end else if (bus_req1) begin
                    state_d = GRANT1;
                end else if (bus_req2) begin
                    state_d = GRANT2;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT1: begin
                // A request drop and a preemption both lead to IDLE alike
                if (!bus_req1) begin
                    state_d = IDLE;
                end else if (at_max_s && bus_req2 && !valid1) begin
                    state_d = IDLE;
                end else begin
                    state_d = GRANT1;
                end
            end
            GRANT2: begin
                if (!bus_req2) begin
                    state_d = IDLE;
                end else if (at_max_s && bus_req1 && !valid2) begin
                    state_d = IDLE;
                end else begin
                    state_d = GRANT2;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if ((state_q == IDLE) && (state_d == GRANT1)) begin
            last_m2_d = 1'b0;
        end else if ((state_q == IDLE) && (state_d == GRANT2)) begin
            last_m2_d = 1'b1;
        end else begin
            last_m2_d = last_m2_q;
        end

        ready1_d = (state_d == GRANT1);
        ready2_d = (state_d == GRANT2);
        gid_d    = grant_code(state_d);
    end

    // State, round-robin flag, start-up guard and registered grant outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            last_m2_q <= 1'b1;
            armed_q   <= 1'b0;
            ready1_q  <= 1'b0;
            ready2_q  <= 1'b0;
            gid_q     <= 2'd0;
        end else begin
            state_q   <= state_d;
            last_m2_q <= last_m2_d;
            armed_q   <= 1'b1;
            ready1_q  <= ready1_d;
            ready2_q  <= ready2_d;
            gid_q     <= gid_d;
        end
    end

    // Master-to-slave mux and slave-to-master demux, keyed on the owner
    always_comb begin
        bus_addr     = 1'b0;
        bus_data     = 1'b0;
        bus_valid    = 1'b0;
        bus_burst    = 1'b0;
        data_rx1     = 1'b0;
        data_rx2     = 1'b0;
        slave_valid1 = 1'b0;
        slave_valid2 = 1'b0;
        slave_ready1 = 1'b0;
        slave_ready2 = 1'b0;
        case (state_q)
            GRANT1: begin
                bus_addr     = addr_tx1;
                bus_data     = data_tx1;
                bus_valid    = valid1;
                bus_burst    = burst_mode1;
                data_rx1     = slave_data_rx;
                slave_valid1 = slave_valid_in;
                slave_ready1 = slave_ready_in;
            end
            GRANT2: begin
                bus_addr     = addr_tx2;
                bus_data     = data_tx2;
                bus_valid    = valid2;
                bus_burst    = burst_mode2;
                data_rx2     = slave_data_rx;
                slave_valid2 = slave_valid_in;
                slave_ready2 = slave_ready_in;
            end
            default: begin
                bus_addr = 1'b0;
            end
        endcase
    end

    assign bus_ready1 = ready1_q;
    assign bus_ready2 = ready2_q;
    assign grant_id   = gid_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter (MAX_HOLD = 8).
module tb_bus_arbiter;

    logic       clock;
    logic       reset_n;
    logic       bus_req1, bus_req2;
    logic       addr_tx1, addr_tx2, data_tx1, data_tx2;
    logic       valid1, valid2, burst_mode1, burst_mode2;
    logic       slave_data_rx, slave_valid_in, slave_ready_in;
    logic       bus_ready1, bus_ready2;
    logic       bus_addr, bus_data, bus_valid, bus_burst;
    logic       data_rx1, data_rx2, slave_valid1, slave_valid2;
    logic       slave_ready1, slave_ready2;
    logic [1:0] grant_id;

    int checks   = 0;
    int failures = 0;

    bus_arbiter #(.MAX_HOLD(8)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .bus_req1       (bus_req1),
        .bus_req2       (bus_req2),
        .addr_tx1       (addr_tx1),
        .addr_tx2       (addr_tx2),
        .data_tx1       (data_tx1),
        .data_tx2       (data_tx2),
        .valid1         (valid1),
        .valid2         (valid2),
        .burst_mode1    (burst_mode1),
        .burst_mode2    (burst_mode2),
        .slave_data_rx  (slave_data_rx),
        .slave_valid_in (slave_valid_in),
        .slave_ready_in (slave_ready_in),
        .bus_ready1     (bus_ready1),
        .bus_ready2     (bus_ready2),
        .bus_addr       (bus_addr),
        .bus_data       (bus_data),
        .bus_valid      (bus_valid),
        .bus_burst      (bus_burst),
        .data_rx1       (data_rx1),
        .data_rx2       (data_rx2),
        .slave_valid1   (slave_valid1),
        .slave_valid2   (slave_valid2),
        .slave_ready1   (slave_ready1),
        .slave_ready2   (slave_ready2),
        .grant_id       (grant_id)
    );

    // 10 time-unit clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_grant(input string tag, input logic r1, input logic r2, input logic [1:0] gid);
        check_eq({tag, "_ready1"}, {31'd0, bus_ready1}, {31'd0, r1});
        check_eq({tag, "_ready2"}, {31'd0, bus_ready2}, {31'd0, r2});
        check_eq({tag, "_gid"}, {30'd0, grant_id}, {30'd0, gid});
    endtask

    // Advance one clock and settle just after the rising edge
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    logic [3:0] pat;
    logic [3:0] v;

    initial begin
        reset_n = 1'b0;
        bus_req1 = 1'b1; bus_req2 = 1'b1;
        addr_tx1 = 1'b1; addr_tx2 = 1'b1; data_tx1 = 1'b0; data_tx2 = 1'b0;
        valid1 = 1'b0; valid2 = 1'b0; burst_mode1 = 1'b0; burst_mode2 = 1'b0;
        slave_data_rx = 1'b1; slave_valid_in = 1'b0; slave_ready_in = 1'b0;

        // Reset holds everything idle despite requests and active lines
        step(); step();
        check_grant("reset", 1'b0, 1'b0, 2'd0);
        check_eq("reset_addr", {31'd0, bus_addr}, 32'd0);
        check_eq("reset_rx1", {31'd0, data_rx1}, 32'd0);
        check_eq("reset_rx2", {31'd0, data_rx2}, 32'd0);

        // Release with both requests high: nothing on first edge, master 1 next
        reset_n = 1'b1;
        step();
        check_grant("first_edge", 1'b0, 1'b0, 2'd0);
        step();
        check_grant("contend_m1", 1'b1, 1'b0, 2'd1);
        check_eq("m1_addr_hi", {31'd0, bus_addr}, 32'd1);
        addr_tx1 = 1'b0;
        #1;
        check_eq("m1_addr_lo", {31'd0, bus_addr}, 32'd0);
        step(); step();
        check_grant("m1_hold", 1'b1, 1'b0, 2'd1);

        // Master 1 releases: one dead cycle, then master 2
        bus_req1 = 1'b0;
        step();
        check_grant("rel_idle", 1'b0, 1'b0, 2'd0);
        check_eq("idle_addr", {31'd0, bus_addr}, 32'd0);
        step();
        check_grant("m2_after", 1'b0, 1'b1, 2'd2);

        // Return-path isolation while master 2 owns the bus
        pat = 4'b1101;
        slave_valid_in = 1'b1;
        slave_ready_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            slave_data_rx = pat[i];
            #1;
            check_eq("iso_rx2", {31'd0, data_rx2}, {31'd0, pat[i]});
            check_eq("iso_rx1", {31'd0, data_rx1}, 32'd0);
            step();
        end
        check_eq("iso_sv2", {31'd0, slave_valid2}, 32'd1);
        check_eq("iso_sv1", {31'd0, slave_valid1}, 32'd0);
        check_eq("iso_sr2", {31'd0, slave_ready2}, 32'd1);
        check_eq("iso_sr1", {31'd0, slave_ready1}, 32'd0);
        check_grant("iso_grant", 1'b0, 1'b1, 2'd2);

        // Asynchronous reset in the middle of GRANT2
        #2;
        reset_n = 1'b0;
        #1;
        check_grant("async_rst", 1'b0, 1'b0, 2'd0);
        check_eq("async_rst_sv2", {31'd0, slave_valid2}, 32'd0);
        bus_req1 = 1'b1;
        step();
        reset_n = 1'b1;
        step();
        check_grant("post_rst_first", 1'b0, 1'b0, 2'd0);
        step();
        check_grant("post_rst_m1", 1'b1, 1'b0, 2'd1);
        bus_req1 = 1'b0;
        bus_req2 = 1'b0;
        step();
        check_grant("post_rst_idle", 1'b0, 1'b0, 2'd0);

        // Single master: mux tracks master 1 lines, master 2 lines ignored
        slave_valid_in = 1'b0;
        slave_ready_in = 1'b0;
        bus_req1 = 1'b1;
        step();
        check_grant("single_m1", 1'b1, 1'b0, 2'd1);
        for (int i = 0; i < 12; i++) begin
            v = 4'(i * 5 + 3);
            addr_tx1 = v[0]; data_tx1 = v[1]; valid1 = v[2]; burst_mode1 = v[3];
            addr_tx2 = ~v[0]; data_tx2 = ~v[1]; valid2 = ~v[2]; burst_mode2 = ~v[3];
            #1;
            check_eq("mux_addr", {31'd0, bus_addr}, {31'd0, v[0]});
            check_eq("mux_data", {31'd0, bus_data}, {31'd0, v[1]});
            check_eq("mux_valid", {31'd0, bus_valid}, {31'd0, v[2]});
            check_eq("mux_burst", {31'd0, bus_burst}, {31'd0, v[3]});
            step();
            check_eq("single_hold", {31'd0, bus_ready1}, 32'd1);
        end
        valid1 = 1'b0; valid2 = 1'b0;
        bus_req1 = 1'b0;
        step();
        check_grant("single_drop", 1'b0, 1'b0, 2'd0);

        // Preemption after 8 cycles of GRANT1 with valid1 low
        bus_req1 = 1'b1;
        step();
        check_grant("pre_m1", 1'b1, 1'b0, 2'd1);
        bus_req2 = 1'b1;
        for (int k = 2; k <= 8; k++) begin
            step();
            check_eq("pre_hold", {31'd0, bus_ready1}, 32'd1);
        end
        step();
        check_grant("pre_idle", 1'b0, 1'b0, 2'd0);
        step();
        check_grant("pre_m2", 1'b0, 1'b1, 2'd2);
        bus_req2 = 1'b0;
        step();
        check_grant("pre_m2_rel", 1'b0, 1'b0, 2'd0);
        step();
        check_grant("defer_m1", 1'b1, 1'b0, 2'd1);

        // Deferred preemption: valid1 high for tenure cycles 7-14
        bus_req2 = 1'b1;
        for (int k = 2; k <= 15; k++) begin
            step();
            check_eq("defer_hold", {31'd0, bus_ready1}, 32'd1);
            valid1 = (k >= 7) && (k <= 14);
            #1;
            check_eq("defer_bus_valid", {31'd0, bus_valid}, {31'd0, valid1});
        end
        step();
        check_grant("defer_idle", 1'b0, 1'b0, 2'd0);
        step();
        check_grant("defer_m2", 1'b0, 1'b1, 2'd2);

        // Request drop coinciding with the preemption cycle behaves as a release
        for (int k = 2; k <= 8; k++) begin
            step();
            check_eq("coinc_hold", {31'd0, bus_ready2}, 32'd1);
            if (k == 8) begin
                bus_req2 = 1'b0;
            end
        end
        step();
        check_grant("coinc_idle", 1'b0, 1'b0, 2'd0);
        step();
        check_grant("coinc_m1", 1'b1, 1'b0, 2'd1);

        // One-cycle request pulse seen in IDLE still yields a one-cycle grant
        bus_req1 = 1'b0;
        step();
        check_grant("pulse_pre_idle", 1'b0, 1'b0, 2'd0);
        bus_req1 = 1'b1;
        step();
        bus_req1 = 1'b0;
        check_grant("pulse_grant", 1'b1, 1'b0, 2'd1);
        step();
        check_grant("pulse_release", 1'b0, 1'b0, 2'd0);
        step();
        check_grant("pulse_stay_idle", 1'b0, 1'b0, 2'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
